// File: rtl/mp_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_add_seq_pkg
// Description : Shared definitions for the multi-precision sequential adder.
//               Holds the limb width and the controller state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package mp_add_seq_pkg;

    // Width of one limb and of the shared adder
    localparam int LIMB_W = 32;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mp_add_seq_pkg
`default_nettype wire

// File: rtl/cla_32bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_32bit
// Description : 32-bit carry-lookahead adder built from 4-bit lookahead
//               groups whose group carries ripple from group to group.
// Ports       : A, B   - addends
//               c_in   - carry in
//               sum    - A + B + c_in (low 32 bits)
//               c_out  - carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module cla_32bit
    import mp_add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] A,
    input  logic [LIMB_W-1:0] B,
    input  logic              c_in,
    output logic [LIMB_W-1:0] sum,
    output logic              c_out
);

    logic [LIMB_W-1:0] w_g;
    logic [LIMB_W-1:0] w_p;
    logic [LIMB_W:0]   w_c;

    assign w_g    = A & B;
    assign w_p    = A ^ B;
    assign w_c[0] = c_in;

    // Each group derives its four internal carries directly from the group
    // carry-in, so only the group carry chain is serial.
    for (genvar k = 0; k < LIMB_W / 4; k++) begin : g_grp
        localparam int B0 = 4 * k;
        assign w_c[B0+1] = w_g[B0]
                         | (w_p[B0] & w_c[B0]);
        assign w_c[B0+2] = w_g[B0+1]
                         | (w_p[B0+1] & w_g[B0])
                         | (w_p[B0+1] & w_p[B0] & w_c[B0]);
        assign w_c[B0+3] = w_g[B0+2]
                         | (w_p[B0+2] & w_g[B0+1])
                         | (w_p[B0+2] & w_p[B0+1] & w_g[B0])
                         | (w_p[B0+2] & w_p[B0+1] & w_p[B0] & w_c[B0]);
        assign w_c[B0+4] = w_g[B0+3]
                         | (w_p[B0+3] & w_g[B0+2])
                         | (w_p[B0+3] & w_p[B0+2] & w_g[B0+1])
                         | (w_p[B0+3] & w_p[B0+2] & w_p[B0+1] & w_g[B0])
                         | (w_p[B0+3] & w_p[B0+2] & w_p[B0+1] & w_p[B0] & w_c[B0]);
    end

    assign sum   = w_p ^ w_c[LIMB_W-1:0];
    assign c_out = w_c[LIMB_W];

endmodule : cla_32bit
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : mp_add_seq
// Description : Multi-precision add/subtract processing one 32-bit limb per
//               cycle through a single shared adder. Subtraction is done as
//               A + ~B + 1 (carry seeded with sub); carry=1 means no borrow.
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_ready   - operand handshake (op_a, op_b, sub)
//               out_valid/out_ready - result handshake (result, carry)
// Revision    : 1.0 - initial release
// ============================================================================
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LIMB_W*NWORDS-1:0] op_a,
    input  logic [LIMB_W*NWORDS-1:0] op_b,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LIMB_W*NWORDS-1:0] result,
    output logic                     carry
);

    localparam int IDX_W = $clog2(NWORDS);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [LIMB_W-1:0] r_a   [NWORDS];
    logic [LIMB_W-1:0] r_b   [NWORDS];
    logic [LIMB_W-1:0] r_res [NWORDS];
    logic              r_sub;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;

    logic [LIMB_W-1:0] w_add_a;
    logic [LIMB_W-1:0] w_add_b;
    logic [LIMB_W-1:0] w_sum;
    logic              w_cout;
    logic              w_last;

    assign w_add_a = r_a[r_idx];
    assign w_add_b = r_b[r_idx] ^ {LIMB_W{r_sub}};
    assign w_last  = (r_idx == IDX_W'(NWORDS - 1));

    cla_32bit u_cla (
        .A     (w_add_a),
        .B     (w_add_b),
        .c_in  (r_carry),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            r_a[i] <= op_a[i*LIMB_W +: LIMB_W];
                            r_b[i] <= op_b[i*LIMB_W +: LIMB_W];
                        end
                        r_sub      <= sub;
                        r_carry    <= sub;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    r_res[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    // Release returns to IDLE; in_valid is not looked at here,
                    // so no new set can be taken on the releasing edge.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NWORDS; g++) begin : g_out
        assign result[g*LIMB_W +: LIMB_W] = r_res[g];
    end

    assign carry     = r_carry;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

endmodule : mp_add_seq
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_add_seq
// Description : Self-checking bench for mp_add_seq (NWORDS=4). Expected
//               values come from a wide-integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry)
    );

    // Reference: sum/difference modulo 2^W; for subtraction carry means A >= B.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation from an IDLE negedge; leaves the bench at a negedge
    // in IDLE with in_valid low. Operands are scrambled after acceptance and
    // in_valid is kept high through RUN, DONE and the releasing edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] er, input logic ec,
                          input int hold);
        int lat;
        check({tag, ":in_ready_idle"}, W'(in_ready), W'(1));
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat  = 1;
        op_a = rnd(); op_b = rnd(); sub = ~s;
        while (out_valid !== 1'b1 && lat < 4 * NW + 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, (W+1)'(lat), (W+1)'(NW + 1));
        check({tag, ":result"}, {1'b0, result}, {1'b0, er});
        check({tag, ":carry"}, W'(carry), W'(ec));
        check({tag, ":in_ready_done"}, W'(in_ready), W'(0));
        for (int i = 0; i < hold; i++) begin
            op_a = rnd();
            @(negedge clk);
            check({tag, ":hold_valid"}, W'(out_valid), W'(1));
            check({tag, ":hold_result"}, {carry, result}, {ec, er});
            check({tag, ":hold_in_ready"}, W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":rel_out_valid"}, W'(out_valid), W'(0));
        check({tag, ":rel_in_ready"}, W'(in_ready), W'(1));
        check({tag, ":idle_retain"}, {carry, result}, {ec, er});
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a, b, ones;
        logic         s;
        logic [W:0]   m;

        ones = '1;

        // Reset state
        @(negedge clk);
        check("rst:in_ready", W'(in_ready), W'(1));
        check("rst:out_valid", W'(out_valid), W'(0));
        check("rst:result", {carry, result}, '0);
        rst = 1'b0;

        // Full carry ripple
        run_op("ripple", ones, W'(1), 1'b0, '0, 1'b1, 0);

        // Per-limb carries
        a = {4{32'ha000ffff}};
        b = {4{32'h7000ffff}};
        m = model(a, b, 1'b0);
        run_op("limbcarry", a, b, 1'b0, m[W-1:0], m[W], 0);

        // Borrow and no-borrow
        run_op("borrow", W'(5), W'(7), 1'b1, {{3{32'hffffffff}}, 32'hfffffffe}, 1'b0, 0);
        run_op("noborrow", W'(7), W'(5), 1'b1, W'(2), 1'b1, 0);

        // Back-pressure for 10 cycles
        a = rnd(); b = rnd();
        m = model(a, b, 1'b0);
        run_op("backpress", a, b, 1'b0, m[W-1:0], m[W], 10);

        // Randomized operations
        for (int i = 0; i < 8; i++) begin
            a = rnd(); b = rnd(); s = 1'($urandom_range(0, 1));
            if (i == 3) b = a;
            m = model(a, b, s);
            run_op("random", a, b, s, m[W-1:0], m[W], int'($urandom_range(0, 3)));
        end

        // Reset in the second RUN cycle
        op_a = rnd(); op_b = rnd(); sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst:out_valid", W'(out_valid), W'(0));
        check("midrst:in_ready", W'(in_ready), W'(1));
        check("midrst:result", {carry, result}, '0);
        rst = 1'b0;
        a = rnd(); b = rnd();
        m = model(a, b, 1'b1);
        run_op("after_rst", a, b, 1'b1, m[W-1:0], m[W], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mp_add_seq
`default_nettype wire
